// File: rtl/fm_demod_pkg.sv
// fm_demod_pkg: shared constants, fixed-point helpers and FSM states
// for the FM quadrature demodulator.
package fm_demod_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BITS       = 10;
  localparam int QUANT      = 1 << BITS;

  localparam int GAIN  = 758;
  localparam int QUAD1 = 804;
  localparam int QUAD3 = 2412;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    ANGLE,
    OUT
  } state_t;

  // Divide by QUANT, truncating toward zero like C integer division.
  function automatic logic signed [31:0] dequantize(
    input logic signed [31:0] v
  );
    logic signed [31:0] bias;
    bias = v[31] ? 32'(QUANT - 1) : 32'sd0;
    return (v + bias) >>> BITS;
  endfunction

  // Product keeping only the low 32 bits.
  function automatic logic signed [31:0] mul32(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    return a * b;
  endfunction

endpackage

// File: rtl/fifo_fwft.sv
// fifo_fwft: generic synchronous first-word-fall-through FIFO.
// dout reads zero while the FIFO is empty.
module fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fm_demod_div.sv
// fm_demod_div: iterative signed 32/32 restoring divider.
// One quotient bit per cycle; quotient truncates toward zero.
module fm_demod_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);

  logic        busy;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  assign rem_sh   = {rem, quo[31]};
  assign diff     = rem_sh - {1'b0, dvs};
  assign quotient = neg ? -quo : quo;

  // Works on magnitudes; the sign is reapplied to the final quotient.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      neg  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
        rem  <= '0;
        quo  <= dividend[31] ? -dividend : dividend;
        dvs  <= divisor[31] ? -divisor : divisor;
        neg  <= dividend[31] ^ divisor[31];
      end else if (busy) begin
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= rem_sh[31:0];
          quo <= {quo[30:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
        if (cnt == 5'd31) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fm_demod.sv
// fm_demod: FM quadrature demodulator (phase difference via atan approx).
// Define FM_DEMOD_SAMPLE_CNT_EN to add the sample_count output.
module fm_demod
  import fm_demod_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] real_in,
  input  logic [DATA_WIDTH-1:0] imag_in,
  input  logic                  in_fifo_wr_en,
  output logic                  in_fifos_full,
  input  logic                  out_fifo_rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_fifo_empty
`ifdef FM_DEMOD_SAMPLE_CNT_EN
  ,
  output logic [31:0]           sample_count
`endif
);

  state_t state;

  logic        re_full;
  logic        im_full;
  logic        re_empty;
  logic        im_empty;
  logic        out_full;
  logic [31:0] re_dout;
  logic [31:0] im_dout;
  logic        in_wr;
  logic        in_pop;
  logic        out_wr;
  logic [31:0] out_din;

  logic signed [31:0] re_q;
  logic signed [31:0] im_q;
  logic signed [31:0] rp;
  logic signed [31:0] ip;
  logic signed [31:0] r_q;
  logic signed [31:0] i_q;
  logic signed [31:0] q_q;
  logic signed [31:0] angle_q;
  logic signed [31:0] ay;
  logic signed [31:0] div_num;
  logic signed [31:0] div_den;
  logic signed [31:0] angle;
  logic               r_pos;
  logic               div_start;
  logic               div_done;
  logic [31:0]        div_quo;

  assign in_fifos_full = re_full || im_full;
  assign in_wr  = in_fifo_wr_en && !in_fifos_full;
  assign in_pop = (state == IDLE) && !re_empty
               && !im_empty && !out_full;
  assign out_wr = (state == OUT);
  assign out_din = dequantize(mul32(GAIN, angle_q));

  fifo_fwft #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_re_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (in_wr),
    .din   (real_in),
    .full  (re_full),
    .rd_en (in_pop),
    .dout  (re_dout),
    .empty (re_empty)
  );

  fifo_fwft #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_im_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (in_wr),
    .din   (imag_in),
    .full  (im_full),
    .rd_en (in_pop),
    .dout  (im_dout),
    .empty (im_empty)
  );

  fifo_fwft #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (out_wr),
    .din   (out_din),
    .full  (out_full),
    .rd_en (out_fifo_rd_en),
    .dout  (data_out),
    .empty (out_fifo_empty)
  );

  // Quadrant-folded atan operands; ay >= 1 keeps the divisor non-zero.
  assign ay      = (i_q[31] ? -i_q : i_q) + 32'sd1;
  assign r_pos   = !r_q[31];
  assign div_num = r_pos ? ((r_q - ay) <<< BITS)
                         : ((r_q + ay) <<< BITS);
  assign div_den = r_pos ? (r_q + ay) : (ay - r_q);

  always_comb begin
    angle = (r_pos ? 32'(QUAD1) : 32'(QUAD3))
          - dequantize(mul32(QUAD1, q_q));
    if (i_q[31]) angle = -angle;
  end

  fm_demod_div u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_num),
    .divisor  (div_den),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      re_q      <= '0;
      im_q      <= '0;
      rp        <= '0;
      ip        <= '0;
      r_q       <= '0;
      i_q       <= '0;
      q_q       <= '0;
      angle_q   <= '0;
      div_start <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (in_pop) begin
            re_q  <= re_dout;
            im_q  <= im_dout;
            state <= MULT;
          end
        end
        MULT: begin
          r_q <= dequantize(mul32(rp, re_q))
               - dequantize(mul32(-ip, im_q));
          i_q <= dequantize(mul32(rp, im_q))
               + dequantize(mul32(-ip, re_q));
          div_start <= 1'b1;
          state     <= DIV;
        end
        DIV: begin
          if (div_done) begin
            q_q   <= div_quo;
            state <= ANGLE;
          end
        end
        ANGLE: begin
          angle_q <= angle;
          state   <= OUT;
        end
        OUT: begin
          rp    <= re_q;
          ip    <= im_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FM_DEMOD_SAMPLE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)       sample_count <= '0;
    else if (out_wr) sample_count <= sample_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fm_demod.sv
// tb_fm_demod: scoreboard bench for fm_demod against a C-style
// integer model of the demodulator arithmetic.
module tb_fm_demod;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] real_in = '0;
  logic [31:0] imag_in = '0;
  logic        in_fifo_wr_en = 1'b0;
  logic        in_fifos_full;
  logic        out_fifo_rd_en = 1'b0;
  logic [31:0] data_out;
  logic        out_fifo_empty;
`ifdef FM_DEMOD_SAMPLE_CNT_EN
  logic [31:0] sample_count;
`endif

  int checks = 0;
  int fails  = 0;
  int sb[$];
  int m_rp = 0;
  int m_ip = 0;

  always #5 clk = ~clk;

  fm_demod dut (
    .clk            (clk),
    .reset          (reset),
    .real_in        (real_in),
    .imag_in        (imag_in),
    .in_fifo_wr_en  (in_fifo_wr_en),
    .in_fifos_full  (in_fifos_full),
    .out_fifo_rd_en (out_fifo_rd_en),
    .data_out       (data_out),
    .out_fifo_empty (out_fifo_empty)
`ifdef FM_DEMOD_SAMPLE_CNT_EN
    ,
    .sample_count   (sample_count)
`endif
  );

  function automatic int dq(input int v);
    return v / 1024;
  endfunction

  function automatic int model(input int re, input int im);
    int r, i, ay, q, ang;
    r  = dq(m_rp * re) - dq(-m_ip * im);
    i  = dq(m_rp * im) + dq(-m_ip * re);
    ay = (i < 0 ? -i : i) + 1;
    if (r >= 0) begin
      q   = ((r - ay) << 10) / (r + ay);
      ang = 804 - dq(804 * q);
    end else begin
      q   = ((r + ay) << 10) / (ay - r);
      ang = 2412 - dq(804 * q);
    end
    if (i < 0) ang = -ang;
    m_rp = re;
    m_ip = im;
    return dq(758 * ang);
  endfunction

  task automatic write_sample(input int re, input int im);
    int n = 0;
    while (in_fifos_full && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (in_fifos_full) begin
      checks++;
      fails++;
      $display("FAIL write_timeout full=%0b required=0", in_fifos_full);
      return;
    end
    real_in = re;
    imag_in = im;
    in_fifo_wr_en = 1'b1;
    sb.push_back(model(re, im));
    @(negedge clk);
    in_fifo_wr_en = 1'b0;
  endtask

  task automatic read_one(input string name);
    int n = 0;
    int exp;
    while (out_fifo_empty && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_fifo_empty || sb.size() == 0) begin
      fails++;
      $display("FAIL %s_timeout empty=%0b queued=%0d",
               name, out_fifo_empty, sb.size());
      return;
    end
    exp = sb.pop_front();
    if (data_out !== exp) begin
      fails++;
      $display("FAIL %s data_out=%h required=%h", name, data_out, exp);
    end
    out_fifo_rd_en = 1'b1;
    @(negedge clk);
    out_fifo_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_fifo_wr_en = 1'b0;
    out_fifo_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_rp = 0;
    m_ip = 0;
  endtask

  task automatic check_idle_flags(input string name);
    checks++;
    if (in_fifos_full !== 1'b0) begin
      fails++;
      $display("FAIL %s_full got=%b required=0", name, in_fifos_full);
    end
    checks++;
    if (out_fifo_empty !== 1'b1) begin
      fails++;
      $display("FAIL %s_empty got=%b required=1", name, out_fifo_empty);
    end
    checks++;
    if (data_out !== 32'h0) begin
      fails++;
      $display("FAIL %s_dout got=%h required=0", name, data_out);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_flags("reset");
  endtask

  task automatic test_zero();
    int n = 0;
    write_sample(0, 0);
    while (out_fifo_empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (data_out !== 32'h0000_04A6) begin
      fails++;
      $display("FAIL zero_const data_out=%h required=000004a6", data_out);
    end
    read_one("zero");
    checks++;
    if (out_fifo_empty !== 1'b1) begin
      fails++;
      $display("FAIL zero_empty_after_read got=%b required=1",
               out_fifo_empty);
    end
  endtask

  task automatic test_quadrants();
    write_sample(32'h400, 0);
    read_one("q_r0i0");
    write_sample(32'h400, 32'h400);
    read_one("q_pos");
    write_sample(32'h400, 0);
    read_one("q_neg_back");
    write_sample(32'h400, -1024);
    read_one("q_sign");
    write_sample(-1024, 0);
    read_one("q_left");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int re, im;
      if (k < 5) begin
        re = $urandom_range(8191) - 4096;
        im = $urandom_range(8191) - 4096;
      end else begin
        re = $urandom;
        im = $urandom;
      end
      write_sample(re, im);
      read_one("random");
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      write_sample($urandom_range(2047) - 1024,
                   $urandom_range(2047) - 1024);
    for (int k = 0; k < 4; k++) read_one("b2b");
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    bit saw_full = 0;
    for (int k = 0; k < 100; k++) begin
      int re, im;
      re = $urandom_range(4095) - 2048;
      im = $urandom_range(4095) - 2048;
      real_in = re;
      imag_in = im;
      in_fifo_wr_en = 1'b1;
      if (in_fifos_full) saw_full = 1;
      else begin
        accepted++;
        sb.push_back(model(re, im));
      end
      @(negedge clk);
    end
    in_fifo_wr_en = 1'b0;
    checks++;
    if (!saw_full) begin
      fails++;
      $display("FAIL bp_full_seen got=0 required=1");
    end
    checks++;
    if (accepted > 32) begin
      fails++;
      $display("FAIL bp_accepted got=%0d required<=32", accepted);
    end
    repeat (1200) @(negedge clk);
    while (sb.size() > 0) read_one("bp_drain");
    repeat (100) @(negedge clk);
    checks++;
    if (out_fifo_empty !== 1'b1) begin
      fails++;
      $display("FAIL bp_extra_output empty=%b required=1",
               out_fifo_empty);
    end
  endtask

  task automatic test_reset_mid_div();
    write_sample(32'h123, 32'h456);
    read_one("mid_pre");
    write_sample(32'h789, -32'sh321);
    repeat (12) @(negedge clk);
    do_reset();
    check_idle_flags("mid_reset");
    write_sample(32'h400, 32'h400);
    read_one("mid_after");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_quadrants();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
